// File: rtl/pwm_fade_multichannel.sv
// rtl/pwm_fade_multichannel.sv - multichannel PWM output stage with period-aligned duty fading
//
// Drives CHANNELS PWM outputs of PWM_W-bit resolution. Each channel has a
// target duty set through the write port; a fade engine walks the live duty
// one LSB toward the target every (fade_rate+1) PWM periods, or jumps to it
// immediately when fade_rate is 0. The live duty only changes on a counter
// wrap, so every PWM period is produced with a single consistent duty.
//
// Optional build macro: PWM_PHASE_STAGGER_EN offsets channel i's compare
// point by i*(2^PWM_W/CHANNELS) counts to spread switching edges over the
// period. Without it all channels compare against the shared counter.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          count/fade enable; low freezes counter, fade engine, outputs
//   wr_en        target write strobe
//   wr_ch        target channel index (out-of-range writes are dropped)
//   wr_data      target duty value
//   fade_rate    fade step interval in PWM periods, 0 = instant
//   pwm_out      registered PWM outputs, one cycle behind the counter
//   period_start one-cycle pulse while the counter sits at 0 after a wrap
//   fading       per-channel flag, live duty differs from target
module pwm_fade_multichannel #(
    parameter int CHANNELS   = 4,
    parameter int PWM_W      = 8,
    parameter int FADE_DIV_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        wr_en,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch,
    input  logic [PWM_W-1:0]            wr_data,
    input  logic [FADE_DIV_W-1:0]       fade_rate,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic                        period_start,
    output logic [CHANNELS-1:0]         fading
);

`ifdef PWM_PHASE_STAGGER_EN
    localparam int PHASE_STEP = (2 ** PWM_W) / CHANNELS;
`endif

    logic [PWM_W-1:0]      r_cnt;
    logic [FADE_DIV_W-1:0] r_div;
    logic [PWM_W-1:0]      r_target [CHANNELS];
    logic [PWM_W-1:0]      r_cur    [CHANNELS];
    logic [CHANNELS-1:0]   r_pwm;
    logic                  r_period_start;

    logic                  w_wrap;
    logic                  w_wr_ok;
    logic [PWM_W-1:0]      w_cmp    [CHANNELS];
    logic [CHANNELS-1:0]   w_pwm_next;

    assign w_wrap  = ena && (r_cnt == '1);
    assign w_wr_ok = (32'(wr_ch) < CHANNELS);

    // Compare point per channel and the next output level. All-ones duty is
    // forced high so the output never drops for the single cnt=max slot.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_PHASE_STAGGER_EN
            w_cmp[i] = r_cnt + PWM_W'(i * PHASE_STEP);
`else
            w_cmp[i] = r_cnt;
`endif
            w_pwm_next[i] = (r_cur[i] == '1) || (r_cur[i] > w_cmp[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            fading[i] = (r_cur[i] != r_target[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_div          <= '0;
            r_pwm          <= '0;
            r_period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_target[i] <= '0;
                r_cur[i]    <= '0;
            end
        end else begin
            // Forced low while disabled since no wrap can occur.
            r_period_start <= w_wrap;

            if (ena) begin
                r_cnt <= r_cnt + 1'b1;
                r_pwm <= w_pwm_next;
            end

            // Target writes bypass ena so firmware can preload while frozen.
            if (wr_en && w_wr_ok) begin
                r_target[wr_ch] <= wr_data;
            end

            // Fade engine reads r_target before any same-cycle write lands,
            // so a write coinciding with a wrap is seen at the next wrap.
            if (w_wrap) begin
                if (fade_rate == '0) begin
                    r_div <= '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_cur[i] <= r_target[i];
                    end
                end else if (r_div >= fade_rate) begin
                    // >= lets a lowered fade_rate take effect at the next wrap.
                    r_div <= '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (r_cur[i] < r_target[i]) begin
                            r_cur[i] <= r_cur[i] + 1'b1;
                        end else if (r_cur[i] > r_target[i]) begin
                            r_cur[i] <= r_cur[i] - 1'b1;
                        end
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_fade_multichannel.sv
// tb/tb_pwm_fade_multichannel.sv - self-checking bench for pwm_fade_multichannel
module tb_pwm_fade_multichannel;

    localparam int NCH = 4;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic [3:0] fade_rate;
    logic [3:0] pwm_out;
    logic       period_start;
    logic [3:0] fading;

    int checks = 0;
    int errors = 0;

    // Reference model: duty and target per channel, period divider, rate.
    int m_cur [NCH];
    int m_tgt [NCH];
    int m_div;
    int m_rate;

    pwm_fade_multichannel #(
        .CHANNELS  (NCH),
        .PWM_W     (8),
        .FADE_DIV_W(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_data     (wr_data),
        .fade_rate   (fade_rate),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .fading      (fading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Duty update applied once per PWM period.
    task automatic model_wrap();
        if (m_rate == 0) begin
            m_div = 0;
            for (int c = 0; c < NCH; c++) m_cur[c] = m_tgt[c];
        end else if (m_div >= m_rate) begin
            m_div = 0;
            for (int c = 0; c < NCH; c++) begin
                if (m_cur[c] < m_tgt[c]) m_cur[c]++;
                else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
            end
        end else begin
            m_div++;
        end
    endtask

    function automatic logic [3:0] model_fading();
        logic [3:0] f;
        for (int c = 0; c < NCH; c++) f[c] = (m_cur[c] != m_tgt[c]);
        return f;
    endfunction

    task automatic set_rate(input int r);
        fade_rate = 4'(r);
        m_rate    = r;
    endtask

    // Called at a negedge where period_start is high (counter at 0).
    // Observes one full PWM period: high-time per channel must equal the
    // model duty (256 for all-ones), period_start only at the end.
    task automatic run_period(input int do_wr, input int ch, input int data);
        int hi [NCH];
        int ps_mid;
        logic ps_end;
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        ps_mid = 0;
        if (do_wr != 0) begin
            wr_en   = 1'b1;
            wr_ch   = 2'(ch);
            wr_data = 8'(data);
            m_tgt[ch] = data;
        end
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            wr_en = 1'b0;
            for (int c = 0; c < NCH; c++) if (pwm_out[c] === 1'b1) hi[c]++;
            if (k < 255 && period_start !== 1'b0) ps_mid++;
        end
        ps_end = period_start;
        for (int c = 0; c < NCH; c++)
            chk($sformatf("duty_ch%0d", c), hi[c], (m_cur[c] == 255) ? 256 : m_cur[c]);
        chk("period_start_mid", ps_mid, 0);
        chk("period_start_end", {31'd0, ps_end}, 1);
        model_wrap();
        chk("fading", {28'd0, fading}, {28'd0, model_fading()});
    endtask

    initial begin
        int n;
        int r;
        int do_wr;
        int ch;
        int data;
        int bad;
        logic [3:0] held;

        for (int c = 0; c < NCH; c++) begin
            m_cur[c] = 0;
            m_tgt[c] = 0;
        end
        m_div  = 0;
        m_rate = 0;

        rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0; fade_rate = '0;
        repeat (3) @(negedge clk);
        chk("reset_pwm_out", {28'd0, pwm_out}, 0);
        chk("reset_fading", {28'd0, fading}, 0);
        chk("reset_period_start", {31'd0, period_start}, 0);

        // First wrap must land exactly 256 cycles after enable.
        rst_n = 1'b1;
        ena   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < 300);
        chk("first_period_len", n, 256);
        model_wrap();
        run_period(0, 0, 0);

        // Instant duty change on ch1.
        run_period(1, 1, 64);
        run_period(0, 0, 0);

        // Constant high then constant low on ch0.
        run_period(1, 0, 255);
        run_period(0, 0, 0);
        run_period(1, 0, 0);
        run_period(0, 0, 0);

        // Slow fade on ch2, up by 4 then down by 3 at 3 periods per step.
        set_rate(2);
        n = 0;
        do begin
            run_period((n == 0) ? 1 : 0, 2, 4);
            n++;
        end while (fading[2] === 1'b1 && n < 20);
        chk("fade_up_periods", n, 12);
        n = 0;
        do begin
            run_period((n == 0) ? 1 : 0, 2, 1);
            n++;
        end while (fading[2] === 1'b1 && n < 20);
        chk("fade_down_periods", n, 9);

        // Freeze with a write pending on ch3.
        set_rate(0);
        ena     = 1'b0;
        wr_en   = 1'b1;
        wr_ch   = 2'd3;
        wr_data = 8'd200;
        m_tgt[3] = 200;
        held = pwm_out;
        bad  = 0;
        repeat (500) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (pwm_out !== held || period_start !== 1'b0) bad++;
        end
        chk("freeze_hold", bad, 0);
        chk("freeze_fading_ch3", {31'd0, fading[3]}, 1);
        ena = 1'b1;
        run_period(0, 0, 0);
        run_period(0, 0, 0);

        // Randomized writes and fade rates against the model.
        for (int p = 0; p < 16; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 3));
                set_rate(r);
            end
            do_wr = int'($urandom_range(0, 1));
            ch    = int'($urandom_range(0, 3));
            data  = int'($urandom_range(0, 255));
            run_period(do_wr, ch, data);
        end

        // Asynchronous reset mid-fade clears outputs without a clock edge.
        set_rate(0);
        run_period(1, 0, 255);
        set_rate(3);
        run_period(1, 1, (m_cur[1] + 128) % 256);
        repeat (37) @(negedge clk);
        chk("pre_reset_pwm0", {31'd0, pwm_out[0]}, 1);
        chk("pre_reset_fading1", {31'd0, fading[1]}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_pwm_out", {28'd0, pwm_out}, 0);
        chk("async_reset_fading", {28'd0, fading}, 0);
        chk("async_reset_period_start", {31'd0, period_start}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
